mem_stage: RTL and testbench
============================

# mem_stage

Pipeline MEM stage of the five-stage MIPS core. It receives EX results into its own EX/MEM register and resolves branches toward fetch. It performs word loads and stores through a request/ready data-memory handshake with a bounded wait, and stalls upstream while an access is outstanding. It then delivers results into a MEM/WB register for write-back.

## Interface
Parameters:
- TIMEOUT, 16, maximum cycles a data access may wait for `i_dmem_ready`; must be at least 1.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- i_MEM_valid  in  1  EX result is a real instruction (0 = bubble).
- i_MEM_data_PCBranch  in  32  branch target.
- i_MEM_data_ALUOut  in  32  ALU result or memory address.
- i_MEM_data_Zero  in  1  ALU zero flag.
- i_MEM_data_Overflow  in  1  ALU signed overflow.
- i_MEM_data_RTData  in  32  store data.
- i_MEM_ctrl_MemRead, i_MEM_ctrl_MemWrite, i_MEM_ctrl_Branch  in  1 each  MEM controls.
- i_WB_data_RegAddrW  in  5  destination register.
- i_WB_ctrl_Mem2Reg, i_WB_ctrl_RegWrite  in  1 each  WB controls.
- o_stall  out  1  freeze the EX stage and everything upstream.
- o_IF_ctrl_PCSrc  out  1  branch taken.
- o_IF_data_PCBranch  out  32  branch target to fetch.
- o_dmem_req  out  1  access request.
- o_dmem_we  out  1  1 = store.
- o_dmem_addr  out  32  word address (bits [1:0] = 0).
- o_dmem_wdata  out  32  store data.
- i_dmem_ready  in  1  access completes this cycle.
- i_dmem_rdata  in  32  load data, valid when ready = 1.
- o_WB_valid  out  1  MEM/WB register holds a real instruction.
- o_WB_data_ALUOut, o_WB_data_MemData  out  32 each  registered results.
- o_WB_data_RegAddrW  out  5  registered destination.
- o_WB_ctrl_Mem2Reg, o_WB_ctrl_RegWrite  out  1 each  registered WB controls.
- o_exc_overflow, o_exc_align, o_exc_buserr  out  1 each  one-cycle exception pulses, registered alongside MEM/WB.

## Operation
- EX/MEM register: loads all inputs on every rising edge where o_stall = 0; holds while o_stall = 1. Field v = i_MEM_valid.
- Memory op: mem = v & (MemRead | MemWrite). Aligned: ALUOut[1:0] == 0.
- Misaligned mem:
  - No request is issued and no stall occurs.
  - Completes immediately with o_exc_align = 1 and RegWrite suppressed.
- FSM RUN / WAIT, with wait counter `cnt` (clog2(TIMEOUT+1) bits):
  - RUN with aligned mem: o_dmem_req = 1.
    - If i_dmem_ready = 1: the access completes this cycle.
    - Otherwise: go to WAIT with cnt = 1.
  - WAIT: o_dmem_req held at 1; addr, we and wdata stay constant (taken from the EX/MEM register).
    - If ready = 1: complete and return to RUN.
    - Else if cnt == TIMEOUT: complete with bus error, return to RUN.
    - Else: cnt++.
  - With TIMEOUT = 1, a miss in RUN times out on the first WAIT cycle.
- o_stall = aligned mem & ~completing-this-cycle. It is combinational from the state, `cnt` and i_dmem_ready.
- o_dmem_we = MemWrite; o_dmem_wdata = RTData; o_dmem_addr = {ALUOut[31:2], 2'b00}.
- Branch: o_IF_ctrl_PCSrc = v & Branch & Zero. o_IF_data_PCBranch = the registered PCBranch. Both are combinational from the EX/MEM register.
- MEM/WB register:
  - Edge where o_stall = 0: loads ALUOut, RegAddrW and Mem2Reg. MemData loads i_dmem_rdata on a completed load and holds its previous value otherwise. o_WB_valid loads v.
  - o_WB_ctrl_RegWrite = v & RegWrite & ~(Overflow | align error | bus error).
  - o_exc_overflow = v & Overflow & RegWrite.
  - Edge where o_stall = 1: bubble (valid, RegWrite, Mem2Reg and all exc = 0; data fields hold).
- Stores never assert RegWrite effects; they pass the RegWrite value through as decoded.

## Timing
- Reset: every register and output is 0, and the FSM is in RUN.
  - Reset asserted mid-WAIT drops o_dmem_req immediately (asynchronous reset) and abandons the access.
- Latency:
  - Non-memory instruction: EX/MEM to MEM/WB in 1 cycle.
  - Memory access: 1 + N cycles, where N is the number of wait cycles before ready (N ≤ TIMEOUT).
- i_dmem_ready is ignored while o_dmem_req = 0.
- rdata is sampled only in the ready cycle.
- Exception pulses last exactly one cycle, on the MEM/WB edge.
- A branch and a memory op never coexist; the branch is resolved in the same cycle the instruction sits in EX/MEM.

## Test plan
- Zero-wait load: ALUOut=0x100, MemRead=1, RegWrite=1, Mem2Reg=1; ready=1 in the same cycle with rdata=0xDEADBEEF -> o_stall never asserted; next edge o_WB_data_MemData=0xDEADBEEF, o_WB_valid=1.
- Store with 3 wait cycles: ALUOut=0x204, RTData=0x12345678 -> req=1, we=1, addr=0x204, wdata held for 4 cycles; o_stall=1 for 3 cycles; upstream input held; WB bubbles for 3 cycles, then valid.
- Timeout with TIMEOUT=4 and ready held low -> o_stall high for 4 cycles, req drops, o_exc_buserr pulses, o_WB_ctrl_RegWrite=0.
- Misaligned load at 0x102 -> o_dmem_req stays 0, no stall, o_exc_align=1, RegWrite=0.
- Branch: Branch=1, Zero=1, PCBranch=0x40 -> PCSrc=1, target 0x40; with Zero=0 -> PCSrc=0. Add with Overflow=1, RegWrite=1 -> o_exc_overflow=1, o_WB_ctrl_RegWrite=0.
- nrst pulsed low in the 2nd WAIT cycle -> all outputs 0 immediately; after release FSM is in RUN and o_dmem_req=0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the five-stage MIPS pipeline.
// Holds the EX/MEM register, resolves branches toward fetch, runs word
// loads/stores over a req/ready data-memory port with a bounded wait,
// and feeds the MEM/WB register (including one-cycle exception pulses).
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        nrst,
    // EX results
    input  logic        i_MEM_valid,
    input  logic [31:0] i_MEM_data_PCBranch,
    input  logic [31:0] i_MEM_data_ALUOut,
    input  logic        i_MEM_data_Zero,
    input  logic        i_MEM_data_Overflow,
    input  logic [31:0] i_MEM_data_RTData,
    input  logic        i_MEM_ctrl_MemRead,
    input  logic        i_MEM_ctrl_MemWrite,
    input  logic        i_MEM_ctrl_Branch,
    input  logic [4:0]  i_WB_data_RegAddrW,
    input  logic        i_WB_ctrl_Mem2Reg,
    input  logic        i_WB_ctrl_RegWrite,
    // upstream control and branch resolution
    output logic        o_stall,
    output logic        o_IF_ctrl_PCSrc,
    output logic [31:0] o_IF_data_PCBranch,
    // data memory port
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ready,
    input  logic [31:0] i_dmem_rdata,
    // MEM/WB register
    output logic        o_WB_valid,
    output logic [31:0] o_WB_data_ALUOut,
    output logic [31:0] o_WB_data_MemData,
    output logic [4:0]  o_WB_data_RegAddrW,
    output logic        o_WB_ctrl_Mem2Reg,
    output logic        o_WB_ctrl_RegWrite,
    output logic        o_exc_overflow,
    output logic        o_exc_align,
    output logic        o_exc_buserr
);

    // Wait counter must be able to hold the value TIMEOUT itself.
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;

    // EX/MEM register fields
    logic        ex_valid_reg;
    logic [31:0] ex_pcbranch_reg;
    logic [31:0] ex_aluout_reg;
    logic        ex_zero_reg;
    logic        ex_overflow_reg;
    logic [31:0] ex_rtdata_reg;
    logic        ex_memread_reg;
    logic        ex_memwrite_reg;
    logic        ex_branch_reg;
    logic [4:0]  ex_regaddr_reg;
    logic        ex_mem2reg_reg;
    logic        ex_regwrite_reg;

    // MEM/WB register fields
    logic        wb_valid_reg;
    logic [31:0] wb_aluout_reg;
    logic [31:0] wb_memdata_reg;
    logic [4:0]  wb_regaddr_reg;
    logic        wb_mem2reg_reg;
    logic        wb_regwrite_reg;
    logic        exc_overflow_reg;
    logic        exc_align_reg;
    logic        exc_buserr_reg;

    // Derived access conditions for the instruction sitting in EX/MEM
    logic is_mem;
    logic aligned;
    logic access;
    logic misalign;
    logic timeout_hit;
    logic load_done;
    logic stall;

    assign is_mem      = ex_valid_reg & (ex_memread_reg | ex_memwrite_reg);
    assign aligned     = (ex_aluout_reg[1:0] == 2'b00);
    assign access      = is_mem & aligned;
    assign misalign    = is_mem & ~aligned;
    // Timeout only fires while waiting; a ready in the same cycle wins.
    assign timeout_hit = access & (state_reg == ST_WAIT) & (cnt_reg == CNT_MAX) & ~i_dmem_ready;
    // Stall for as long as an aligned access has not finished this cycle.
    assign stall       = access & ~i_dmem_ready & ~timeout_hit;
    assign load_done   = access & ex_memread_reg & i_dmem_ready;

    // EX/MEM register: capture EX results unless the stage is stalled
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ex_valid_reg    <= 1'b0;
            ex_pcbranch_reg <= 32'd0;
            ex_aluout_reg   <= 32'd0;
            ex_zero_reg     <= 1'b0;
            ex_overflow_reg <= 1'b0;
            ex_rtdata_reg   <= 32'd0;
            ex_memread_reg  <= 1'b0;
            ex_memwrite_reg <= 1'b0;
            ex_branch_reg   <= 1'b0;
            ex_regaddr_reg  <= 5'd0;
            ex_mem2reg_reg  <= 1'b0;
            ex_regwrite_reg <= 1'b0;
        end else if (!stall) begin
            ex_valid_reg    <= i_MEM_valid;
            ex_pcbranch_reg <= i_MEM_data_PCBranch;
            ex_aluout_reg   <= i_MEM_data_ALUOut;
            ex_zero_reg     <= i_MEM_data_Zero;
            ex_overflow_reg <= i_MEM_data_Overflow;
            ex_rtdata_reg   <= i_MEM_data_RTData;
            ex_memread_reg  <= i_MEM_ctrl_MemRead;
            ex_memwrite_reg <= i_MEM_ctrl_MemWrite;
            ex_branch_reg   <= i_MEM_ctrl_Branch;
            ex_regaddr_reg  <= i_WB_data_RegAddrW;
            ex_mem2reg_reg  <= i_WB_ctrl_Mem2Reg;
            ex_regwrite_reg <= i_WB_ctrl_RegWrite;
        end
    end

    // Access FSM state and wait counter
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic: a miss in RUN starts counting wait cycles from 1
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_RUN: begin
                if (access && !i_dmem_ready) begin
                    state_next = ST_WAIT;
                    cnt_next   = CNT_ONE;
                end
            end
            ST_WAIT: begin
                if (i_dmem_ready || (cnt_reg == CNT_MAX)) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = ST_RUN;
                cnt_next   = '0;
            end
        endcase
    end

    // MEM/WB register: results on completion, bubble while stalled
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wb_valid_reg     <= 1'b0;
            wb_aluout_reg    <= 32'd0;
            wb_memdata_reg   <= 32'd0;
            wb_regaddr_reg   <= 5'd0;
            wb_mem2reg_reg   <= 1'b0;
            wb_regwrite_reg  <= 1'b0;
            exc_overflow_reg <= 1'b0;
            exc_align_reg    <= 1'b0;
            exc_buserr_reg   <= 1'b0;
        end else if (stall) begin
            wb_valid_reg     <= 1'b0;
            wb_mem2reg_reg   <= 1'b0;
            wb_regwrite_reg  <= 1'b0;
            exc_overflow_reg <= 1'b0;
            exc_align_reg    <= 1'b0;
            exc_buserr_reg   <= 1'b0;
        end else begin
            wb_valid_reg     <= ex_valid_reg;
            wb_aluout_reg    <= ex_aluout_reg;
            wb_regaddr_reg   <= ex_regaddr_reg;
            wb_mem2reg_reg   <= ex_mem2reg_reg;
            if (load_done) begin
                wb_memdata_reg <= i_dmem_rdata;
            end
            // Any exception on this instruction cancels its register write.
            wb_regwrite_reg  <= ex_valid_reg & ex_regwrite_reg
                              & ~(ex_overflow_reg | misalign | timeout_hit);
            exc_overflow_reg <= ex_valid_reg & ex_overflow_reg & ex_regwrite_reg;
            exc_align_reg    <= misalign;
            exc_buserr_reg   <= timeout_hit;
        end
    end

    // Combinational outputs driven from the EX/MEM register
    assign o_stall            = stall;
    assign o_IF_ctrl_PCSrc    = ex_valid_reg & ex_branch_reg & ex_zero_reg;
    assign o_IF_data_PCBranch = ex_pcbranch_reg;
    assign o_dmem_req         = access;
    assign o_dmem_we          = ex_memwrite_reg;
    assign o_dmem_addr        = {ex_aluout_reg[31:2], 2'b00};
    assign o_dmem_wdata       = ex_rtdata_reg;

    assign o_WB_valid         = wb_valid_reg;
    assign o_WB_data_ALUOut   = wb_aluout_reg;
    assign o_WB_data_MemData  = wb_memdata_reg;
    assign o_WB_data_RegAddrW = wb_regaddr_reg;
    assign o_WB_ctrl_Mem2Reg  = wb_mem2reg_reg;
    assign o_WB_ctrl_RegWrite = wb_regwrite_reg;
    assign o_exc_overflow     = exc_overflow_reg;
    assign o_exc_align        = exc_align_reg;
    assign o_exc_buserr       = exc_buserr_reg;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenarios plus a randomized instruction stream
// checked against a cycle-count model of the MEM stage.
module tb_mem_stage;

    localparam int TMO = 4;

    typedef struct packed {
        logic        v;
        logic [1:0]  kind;   // 0 alu, 1 load, 2 store, 3 branch
        logic [31:0] alu;
        logic [31:0] rt;
        logic [31:0] pcb;
        logic        z;
        logic        ovf;
        logic        rw;
        logic        m2r;
        logic [4:0]  ra;
        logic [2:0]  wn;     // wait cycles before memory answers
    } instr_t;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        i_MEM_valid = 1'b0;
    logic [31:0] i_MEM_data_PCBranch = '0;
    logic [31:0] i_MEM_data_ALUOut = '0;
    logic        i_MEM_data_Zero = 1'b0;
    logic        i_MEM_data_Overflow = 1'b0;
    logic [31:0] i_MEM_data_RTData = '0;
    logic        i_MEM_ctrl_MemRead = 1'b0;
    logic        i_MEM_ctrl_MemWrite = 1'b0;
    logic        i_MEM_ctrl_Branch = 1'b0;
    logic [4:0]  i_WB_data_RegAddrW = '0;
    logic        i_WB_ctrl_Mem2Reg = 1'b0;
    logic        i_WB_ctrl_RegWrite = 1'b0;
    logic        i_dmem_ready = 1'b0;
    logic [31:0] i_dmem_rdata = '0;
    logic        o_stall, o_IF_ctrl_PCSrc, o_dmem_req, o_dmem_we;
    logic [31:0] o_IF_data_PCBranch, o_dmem_addr, o_dmem_wdata;
    logic        o_WB_valid, o_WB_ctrl_Mem2Reg, o_WB_ctrl_RegWrite;
    logic [31:0] o_WB_data_ALUOut, o_WB_data_MemData;
    logic [4:0]  o_WB_data_RegAddrW;
    logic        o_exc_overflow, o_exc_align, o_exc_buserr;

    int checks = 0;
    int failures = 0;
    instr_t cur, pend;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk(clk), .nrst(nrst),
        .i_MEM_valid(i_MEM_valid), .i_MEM_data_PCBranch(i_MEM_data_PCBranch),
        .i_MEM_data_ALUOut(i_MEM_data_ALUOut), .i_MEM_data_Zero(i_MEM_data_Zero),
        .i_MEM_data_Overflow(i_MEM_data_Overflow), .i_MEM_data_RTData(i_MEM_data_RTData),
        .i_MEM_ctrl_MemRead(i_MEM_ctrl_MemRead), .i_MEM_ctrl_MemWrite(i_MEM_ctrl_MemWrite),
        .i_MEM_ctrl_Branch(i_MEM_ctrl_Branch), .i_WB_data_RegAddrW(i_WB_data_RegAddrW),
        .i_WB_ctrl_Mem2Reg(i_WB_ctrl_Mem2Reg), .i_WB_ctrl_RegWrite(i_WB_ctrl_RegWrite),
        .o_stall(o_stall), .o_IF_ctrl_PCSrc(o_IF_ctrl_PCSrc), .o_IF_data_PCBranch(o_IF_data_PCBranch),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_wdata(o_dmem_wdata), .i_dmem_ready(i_dmem_ready), .i_dmem_rdata(i_dmem_rdata),
        .o_WB_valid(o_WB_valid), .o_WB_data_ALUOut(o_WB_data_ALUOut),
        .o_WB_data_MemData(o_WB_data_MemData), .o_WB_data_RegAddrW(o_WB_data_RegAddrW),
        .o_WB_ctrl_Mem2Reg(o_WB_ctrl_Mem2Reg), .o_WB_ctrl_RegWrite(o_WB_ctrl_RegWrite),
        .o_exc_overflow(o_exc_overflow), .o_exc_align(o_exc_align), .o_exc_buserr(o_exc_buserr)
    );

    function automatic instr_t mk(input logic v, input logic [1:0] kind, input logic [31:0] alu,
                                  input logic [31:0] rt, input logic [31:0] pcb, input logic z,
                                  input logic ovf, input logic rw, input logic m2r, input logic [4:0] ra);
        instr_t t;
        t.v = v; t.kind = kind; t.alu = alu; t.rt = rt; t.pcb = pcb; t.z = z;
        t.ovf = ovf; t.rw = rw; t.m2r = m2r; t.ra = ra; t.wn = 3'd0;
        return t;
    endfunction

    task automatic drive(input instr_t t);
        i_MEM_valid         = t.v;
        i_MEM_data_PCBranch = t.pcb;
        i_MEM_data_ALUOut   = t.alu;
        i_MEM_data_Zero     = t.z;
        i_MEM_data_Overflow = t.ovf;
        i_MEM_data_RTData   = t.rt;
        i_MEM_ctrl_MemRead  = (t.kind == 2'd1);
        i_MEM_ctrl_MemWrite = (t.kind == 2'd2);
        i_MEM_ctrl_Branch   = (t.kind == 2'd3);
        i_WB_data_RegAddrW  = t.ra;
        i_WB_ctrl_Mem2Reg   = t.m2r;
        i_WB_ctrl_RegWrite  = t.rw;
    endtask

    task automatic bubble();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic gen_pend();
        pend.v    = ($urandom % 5) != 0;
        pend.kind = 2'($urandom % 4);
        pend.alu  = $urandom;
        if (($urandom % 4) != 0) pend.alu[1:0] = 2'b00;
        pend.rt   = $urandom;
        pend.pcb  = $urandom;
        pend.z    = 1'($urandom % 2);
        pend.ovf  = ($urandom % 5) == 0;
        pend.rw   = 1'($urandom % 2);
        pend.m2r  = 1'($urandom % 2);
        pend.ra   = 5'($urandom);
        pend.wn   = 3'($urandom_range(0, 6));
    endtask

    task automatic test_reset();
        bubble();
        #1;
        checks++;
        if ({o_stall, o_IF_ctrl_PCSrc, o_IF_data_PCBranch, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata,
             o_WB_valid, o_WB_data_ALUOut, o_WB_data_MemData, o_WB_data_RegAddrW, o_WB_ctrl_Mem2Reg,
             o_WB_ctrl_RegWrite, o_exc_overflow, o_exc_align, o_exc_buserr} !== '0) begin
            failures++; $display("FAIL reset_outputs got=nonzero required=all zero");
        end
        @(negedge clk);
        nrst = 1'b1;
        step();
        $display("test_reset done");
    endtask

    task automatic test_zero_wait_load();
        drive(mk(1, 1, 32'h100, 0, 0, 0, 0, 1, 1, 5'd3));
        step();
        bubble();
        i_dmem_ready = 1'b1; i_dmem_rdata = 32'hDEADBEEF;
        #1;
        checks++;
        if (o_stall !== 1'b0) begin failures++; $display("FAIL zw_stall got=%b required=0", o_stall); end
        checks++;
        if ({o_dmem_req, o_dmem_we, o_dmem_addr} !== {1'b1, 1'b0, 32'h100}) begin
            failures++; $display("FAIL zw_req got=%b/%b/%h required=1/0/00000100", o_dmem_req, o_dmem_we, o_dmem_addr);
        end
        step();
        i_dmem_ready = 1'b0;
        checks++;
        if (o_WB_data_MemData !== 32'hDEADBEEF) begin failures++; $display("FAIL zw_memdata got=%h required=deadbeef", o_WB_data_MemData); end
        checks++;
        if ({o_WB_valid, o_WB_ctrl_RegWrite, o_WB_ctrl_Mem2Reg, o_WB_data_RegAddrW} !== {3'b111, 5'd3}) begin
            failures++; $display("FAIL zw_wbctrl got=%b%b%b ra=%0d required=111 ra=3", o_WB_valid, o_WB_ctrl_RegWrite, o_WB_ctrl_Mem2Reg, o_WB_data_RegAddrW);
        end
        $display("test_zero_wait_load done");
    endtask

    task automatic test_store_wait3();
        drive(mk(1, 2, 32'h204, 32'h12345678, 0, 0, 0, 0, 0, 5'd0));
        step();
        // a following instruction waits upstream the whole time
        drive(mk(1, 0, 32'hAAAA0000, 0, 0, 0, 0, 1, 0, 5'd7));
        for (int i = 0; i < 4; i++) begin
            i_dmem_ready = (i == 3);
            #1;
            checks++;
            if (o_stall !== (i < 3)) begin failures++; $display("FAIL st_stall cyc=%0d got=%b required=%b", i, o_stall, (i < 3)); end
            checks++;
            if ({o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata} !== {1'b1, 1'b1, 32'h204, 32'h12345678}) begin
                failures++; $display("FAIL st_bus cyc=%0d got=%b/%b/%h/%h required=1/1/00000204/12345678", i, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata);
            end
            step();
            i_dmem_ready = 1'b0;
            checks++;
            if (o_WB_valid !== (i == 3)) begin failures++; $display("FAIL st_wbvalid cyc=%0d got=%b required=%b", i, o_WB_valid, (i == 3)); end
        end
        checks++;
        if ({o_WB_data_ALUOut, o_WB_ctrl_RegWrite} !== {32'h204, 1'b0}) begin
            failures++; $display("FAIL st_wbdata got=%h/%b required=00000204/0", o_WB_data_ALUOut, o_WB_ctrl_RegWrite);
        end
        bubble();
        step();
        checks++;
        if ({o_WB_valid, o_WB_data_ALUOut, o_WB_ctrl_RegWrite, o_WB_data_RegAddrW} !== {1'b1, 32'hAAAA0000, 1'b1, 5'd7}) begin
            failures++; $display("FAIL st_next got=%b/%h/%b/%0d required=1/aaaa0000/1/7", o_WB_valid, o_WB_data_ALUOut, o_WB_ctrl_RegWrite, o_WB_data_RegAddrW);
        end
        $display("test_store_wait3 done");
    endtask

    task automatic test_timeout();
        drive(mk(1, 1, 32'h300, 0, 0, 0, 0, 1, 1, 5'd9));
        step();
        bubble();
        i_dmem_ready = 1'b0;
        for (int i = 0; i <= TMO; i++) begin
            #1;
            checks++;
            if ({o_stall, o_dmem_req} !== {(i < TMO), 1'b1}) begin
                failures++; $display("FAIL to_stall cyc=%0d got=%b%b required=%b1", i, o_stall, o_dmem_req, (i < TMO));
            end
            step();
        end
        checks++;
        if ({o_WB_valid, o_exc_buserr, o_WB_ctrl_RegWrite} !== 3'b110) begin
            failures++; $display("FAIL to_wb got=%b%b%b required=110", o_WB_valid, o_exc_buserr, o_WB_ctrl_RegWrite);
        end
        checks++;
        if (o_WB_data_MemData !== 32'hDEADBEEF) begin failures++; $display("FAIL to_memhold got=%h required=deadbeef", o_WB_data_MemData); end
        checks++;
        if (o_dmem_req !== 1'b0) begin failures++; $display("FAIL to_reqdrop got=%b required=0", o_dmem_req); end
        step();
        checks++;
        if (o_exc_buserr !== 1'b0) begin failures++; $display("FAIL to_pulse got=%b required=0", o_exc_buserr); end
        $display("test_timeout done");
    endtask

    task automatic test_misaligned();
        drive(mk(1, 1, 32'h102, 0, 0, 0, 0, 1, 1, 5'd4));
        step();
        bubble();
        i_dmem_ready = 1'b1; i_dmem_rdata = 32'h55555555;
        #1;
        checks++;
        if ({o_dmem_req, o_stall} !== 2'b00) begin failures++; $display("FAIL mis_req got=%b%b required=00", o_dmem_req, o_stall); end
        step();
        i_dmem_ready = 1'b0;
        checks++;
        if ({o_WB_valid, o_exc_align, o_WB_ctrl_RegWrite} !== 3'b110) begin
            failures++; $display("FAIL mis_wb got=%b%b%b required=110", o_WB_valid, o_exc_align, o_WB_ctrl_RegWrite);
        end
        checks++;
        if (o_WB_data_MemData !== 32'hDEADBEEF) begin failures++; $display("FAIL mis_memhold got=%h required=deadbeef", o_WB_data_MemData); end
        step();
        checks++;
        if (o_exc_align !== 1'b0) begin failures++; $display("FAIL mis_pulse got=%b required=0", o_exc_align); end
        $display("test_misaligned done");
    endtask

    task automatic test_branch_overflow();
        drive(mk(1, 3, 0, 0, 32'h40, 1, 0, 0, 0, 0));
        step();
        drive(mk(1, 3, 0, 0, 32'h80, 0, 0, 0, 0, 0));
        #1;
        checks++;
        if ({o_IF_ctrl_PCSrc, o_IF_data_PCBranch} !== {1'b1, 32'h40}) begin
            failures++; $display("FAIL br_taken got=%b/%h required=1/00000040", o_IF_ctrl_PCSrc, o_IF_data_PCBranch);
        end
        step();
        drive(mk(1, 0, 32'h7FFFFFFF, 0, 0, 0, 1, 1, 0, 5'd2));
        #1;
        checks++;
        if ({o_IF_ctrl_PCSrc, o_IF_data_PCBranch} !== {1'b0, 32'h80}) begin
            failures++; $display("FAIL br_nottaken got=%b/%h required=0/00000080", o_IF_ctrl_PCSrc, o_IF_data_PCBranch);
        end
        step();
        bubble();
        step();
        checks++;
        if ({o_WB_valid, o_exc_overflow, o_WB_ctrl_RegWrite} !== 3'b110) begin
            failures++; $display("FAIL ovf_wb got=%b%b%b required=110", o_WB_valid, o_exc_overflow, o_WB_ctrl_RegWrite);
        end
        step();
        checks++;
        if (o_exc_overflow !== 1'b0) begin failures++; $display("FAIL ovf_pulse got=%b required=0", o_exc_overflow); end
        $display("test_branch_overflow done");
    endtask

    task automatic test_reset_mid_wait();
        int n;
        drive(mk(1, 0, 32'hCAFE, 0, 0, 0, 0, 1, 0, 5'd5));
        step();
        drive(mk(1, 1, 32'h400, 0, 0, 0, 0, 1, 1, 5'd6));
        i_dmem_ready = 1'b0;
        step();
        bubble();
        step();
        step();
        checks++;
        if ({o_dmem_req, o_WB_data_ALUOut} !== {1'b1, 32'hCAFE}) begin
            failures++; $display("FAIL rst_pre got=%b/%h required=1/0000cafe", o_dmem_req, o_WB_data_ALUOut);
        end
        nrst = 1'b0;
        #1;
        checks++;
        if ({o_stall, o_IF_ctrl_PCSrc, o_IF_data_PCBranch, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata,
             o_WB_valid, o_WB_data_ALUOut, o_WB_data_MemData, o_WB_data_RegAddrW, o_WB_ctrl_Mem2Reg,
             o_WB_ctrl_RegWrite, o_exc_overflow, o_exc_align, o_exc_buserr} !== '0) begin
            failures++; $display("FAIL rst_async got=nonzero required=all zero (req=%b alu=%h)", o_dmem_req, o_WB_data_ALUOut);
        end
        step();
        nrst = 1'b1;
        step();
        checks++;
        if ({o_dmem_req, o_stall} !== 2'b00) begin failures++; $display("FAIL rst_after got=%b%b required=00", o_dmem_req, o_stall); end
        // a fresh access must see the full wait budget again
        drive(mk(1, 1, 32'h500, 0, 0, 0, 0, 1, 0, 5'd1));
        step();
        bubble();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (o_stall === 1'b1) n++;
            step();
        end
        checks++;
        if (n != TMO) begin failures++; $display("FAIL rst_run_stalls got=%0d required=%0d", n, TMO); end
        $display("test_reset_mid_wait done");
    endtask

    task automatic test_random(input int ncyc);
        logic is_mem, misal, amem, done, bus, exp_stall, mem_known, exp_req;
        logic e_valid, e_rw, e_m2r, e_eo, e_ea, e_eb;
        logic [31:0] e_alu, e_mem;
        logic [4:0]  e_ra;
        int k;
        mem_known = 1'b0; k = 0;
        e_valid = 0; e_rw = 0; e_m2r = 0; e_eo = 0; e_ea = 0; e_eb = 0;
        e_alu = '0; e_mem = '0; e_ra = '0;
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(cur);
        step();
        gen_pend();
        drive(pend);
        for (int c = 0; c < ncyc; c++) begin
            is_mem = cur.v && (cur.kind == 2'd1 || cur.kind == 2'd2);
            misal  = is_mem && (cur.alu[1:0] != 2'b00);
            amem   = is_mem && !misal;
            i_dmem_ready = amem ? (k == int'(cur.wn)) : 1'($urandom % 2);
            i_dmem_rdata = $urandom;
            // memory answers after wn cycles; give up once TMO wait cycles have elapsed
            done      = !amem || (k == int'(cur.wn)) || (k == TMO);
            bus       = amem && (k == TMO) && (int'(cur.wn) > TMO);
            exp_stall = amem && !done;
            exp_req   = amem;
            #1;
            checks++;
            if ({o_stall, o_dmem_req} !== {exp_stall, exp_req}) begin
                failures++; $display("FAIL rnd_stall cyc=%0d got=%b%b required=%b%b", c, o_stall, o_dmem_req, exp_stall, exp_req);
            end
            if (amem) begin
                checks++;
                if ({o_dmem_we, o_dmem_addr, o_dmem_wdata} !== {cur.kind == 2'd2, cur.alu[31:2], 2'b00, cur.rt}) begin
                    failures++; $display("FAIL rnd_bus cyc=%0d got=%b/%h/%h required=%b/%h/%h", c, o_dmem_we, o_dmem_addr, o_dmem_wdata, cur.kind == 2'd2, {cur.alu[31:2], 2'b00}, cur.rt);
                end
            end
            checks++;
            if ({o_IF_ctrl_PCSrc, o_IF_data_PCBranch} !== {cur.v && cur.kind == 2'd3 && cur.z, cur.pcb}) begin
                failures++; $display("FAIL rnd_branch cyc=%0d got=%b/%h required=%b/%h", c, o_IF_ctrl_PCSrc, o_IF_data_PCBranch, cur.v && cur.kind == 2'd3 && cur.z, cur.pcb);
            end
            if (exp_stall) begin
                e_valid = 0; e_rw = 0; e_m2r = 0; e_eo = 0; e_ea = 0; e_eb = 0;
                k++;
            end else begin
                e_valid = cur.v; e_alu = cur.alu; e_ra = cur.ra; e_m2r = cur.m2r;
                if (amem && cur.kind == 2'd1 && !bus) begin e_mem = i_dmem_rdata; mem_known = 1'b1; end
                e_rw = cur.v && cur.rw && !(cur.ovf || misal || bus);
                e_eo = cur.v && cur.ovf && cur.rw;
                e_ea = misal;
                e_eb = bus;
                cur = pend;
                k = 0;
                gen_pend();
            end
            step();
            checks++;
            if ({o_WB_valid, o_WB_ctrl_RegWrite, o_WB_ctrl_Mem2Reg, o_exc_overflow, o_exc_align, o_exc_buserr}
                !== {e_valid, e_rw, e_m2r, e_eo, e_ea, e_eb}) begin
                failures++; $display("FAIL rnd_wbctrl cyc=%0d got=%b%b%b%b%b%b required=%b%b%b%b%b%b", c,
                    o_WB_valid, o_WB_ctrl_RegWrite, o_WB_ctrl_Mem2Reg, o_exc_overflow, o_exc_align, o_exc_buserr,
                    e_valid, e_rw, e_m2r, e_eo, e_ea, e_eb);
            end
            checks++;
            if ({o_WB_data_ALUOut, o_WB_data_RegAddrW} !== {e_alu, e_ra}) begin
                failures++; $display("FAIL rnd_wbdata cyc=%0d got=%h/%0d required=%h/%0d", c, o_WB_data_ALUOut, o_WB_data_RegAddrW, e_alu, e_ra);
            end
            if (mem_known) begin
                checks++;
                if (o_WB_data_MemData !== e_mem) begin
                    failures++; $display("FAIL rnd_memdata cyc=%0d got=%h required=%h", c, o_WB_data_MemData, e_mem);
                end
            end
            drive(pend);
            i_dmem_ready = 1'b0;
        end
        $display("test_random done cycles=%0d", ncyc);
    endtask

    initial begin
        test_reset();
        test_zero_wait_load();
        test_store_wait3();
        test_timeout();
        test_misaligned();
        test_branch_overflow();
        test_reset_mid_wait();
        test_random(1500);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
